nv_nvdla_cdma_wt_wgs_splitter: RTL and testbench
================================================

Name: nv_nvdla_cdma_wt_wgs_splitter

Overview:
- Sits directly downstream of the CDMA weight-group-status FIFO. Consumes one 32-bit weight-group descriptor per FIFO pop.
- Converts each descriptor into a sequence of aligned weight-read DMA requests, counted in 32-byte atoms.
- Keeps a running weight address across the groups of one layer. Pulses layer_done after the last group's final burst is accepted.

Parameters:
MAX_BURST, 8, max atoms per DMA request; power of two, 2..16
BURST_W, 3, log2(MAX_BURST); width of dma_req_size

Ports:
clk  in  1  core clock
reset_  in  1  asynchronous active-low reset
wgs_rd_req  in  1  FIFO output valid
wgs_rd_ready  out  1  pop strobe back to FIFO (pop when req && ready)
wgs_rd_data  in  32  descriptor: [15:0] atom count, [16] last-group flag, [31:17] reserved/ignored
layer_start  in  1  single-cycle pulse: load base address, arm block
reg2dp_weight_addr  in  32  layer weight base byte address; bits [4:0] ignored, treated as 0
dma_req_valid  out  1  request valid
dma_req_ready  in  1  downstream accepts
dma_req_addr  out  32  byte address, bits [4:0] always 0
dma_req_size  out  BURST_W  atoms minus 1
busy  out  1  high in any state other than IDLE
layer_done  out  1  one-cycle pulse at layer completion

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low on reset_. Outputs at reset:
  - wgs_rd_ready = 0, dma_req_valid = 0, dma_req_addr = 0, dma_req_size = 0, busy = 0, layer_done = 0.
  - State = IDLE. Internal address and remaining-count registers = 0.
- Reset asserted mid-layer discards all progress. Nothing is re-issued after reset.
- State machine:
  - IDLE:
    - On layer_start: addr_atom <= reg2dp_weight_addr[31:5]; go to FETCH.
    - wgs_rd_ready = 0.
  - FETCH:
    - wgs_rd_ready = 1.
    - On wgs_rd_req: latch remaining = data[15:0] and last = data[16].
    - If count != 0, go to ISSUE.
    - If count == 0 and last, go to DONE.
    - If count == 0 and not last, stay in FETCH (empty group skipped).
  - ISSUE:
    - dma_req_valid = 1.
    - Burst atoms n = min(remaining, MAX_BURST - (addr_atom mod MAX_BURST)). A burst never crosses a MAX_BURST*32-byte boundary.
    - dma_req_addr = {addr_atom, 5'b0}; dma_req_size = n - 1.
    - On dma_req_ready: addr_atom += n; remaining -= n.
    - If remaining becomes 0: go to DONE if last, otherwise FETCH.
  - DONE: layer_done = 1 for exactly one cycle, then IDLE.
- Request outputs are registered. While dma_req_valid && !dma_req_ready, addr and size stay stable.
- Back-to-back bursts are allowed: a new request is presented the cycle after acceptance, with no bubble.
- Group-to-group turnaround costs exactly one FETCH cycle when the FIFO is non-empty.
- Address arithmetic:
  - 27-bit atom address, wraps modulo 2^27; no error is flagged on wrap.
  - remaining is 16 bits, so a 65535-atom group is legal.
- layer_start is ignored in every state except IDLE.
- layer_start and DONE in the same cycle: layer_start is ignored, because the FSM is not yet in IDLE.
- wgs_rd_ready never asserts outside FETCH, so no descriptor is lost.

Optional Feature:
- Macro: NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN.
- When defined:
  - Adds outputs perf_burst_cnt[31:0] (increments on each dma_req_valid && dma_req_ready) and perf_stall_cnt[31:0] (increments on each dma_req_valid && !dma_req_ready).
  - Both counters clear on layer_start accepted in IDLE and on reset.
  - Both saturate at 0xFFFFFFFF.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Aligned multi-burst:
  - Stimulus: base 0x1000, MAX_BURST 8; descriptor {last=1, count=20}; ready tied 1.
  - Required: bursts (0x1000, size 7), (0x1100, size 7), (0x1200, size 3); layer_done 1 cycle after the third accept.
- Misaligned start:
  - Stimulus: base 0x1060 (atom offset 3); descriptor {last=1, count=10}.
  - Required: (0x1060, size 4), (0x1100, size 4).
- Address carries across groups:
  - Stimulus: descriptors {0,5} then {1,3}; base 0.
  - Required: (0x0, size 4), (0xA0, size 2); one FETCH cycle between groups; single layer_done.
- Zero-count groups:
  - Stimulus: descriptor {0,0} then {1,0}.
  - Required: no DMA requests; layer_done asserted; both entries popped.
- Backpressure:
  - Stimulus: hold dma_req_ready = 0 for 5 cycles mid-burst.
  - Required: addr and size stable throughout; no pop; with the perf macro defined, perf_stall_cnt = 5.
- Reset and ignored start:
  - Stimulus: assert reset_ low during ISSUE; afterwards pulse layer_start while busy.
  - Required: all outputs return to 0 and state returns to IDLE; the layer_start pulse while busy is ignored (no base reload).

Source files
------------

// File: rtl/nv_nvdla_cdma_wt_wgs_splitter_if.sv
// Handshake bundle between the WGS FIFO, the weight splitter and the weight DMA.
// The master modport is the splitter side; slave is the FIFO/DMA side.
interface nv_nvdla_cdma_wt_wgs_splitter_if #(
    parameter int BURST_W = 3
);
    logic               wgs_rd_req;
    logic               wgs_rd_ready;
    logic [31:0]        wgs_rd_data;
    logic               dma_req_valid;
    logic               dma_req_ready;
    logic [31:0]        dma_req_addr;
    logic [BURST_W-1:0] dma_req_size;

    modport master (
        input  wgs_rd_req,
        input  wgs_rd_data,
        input  dma_req_ready,
        output wgs_rd_ready,
        output dma_req_valid,
        output dma_req_addr,
        output dma_req_size
    );

    modport slave (
        output wgs_rd_req,
        output wgs_rd_data,
        output dma_req_ready,
        input  wgs_rd_ready,
        input  dma_req_valid,
        input  dma_req_addr,
        input  dma_req_size
    );
endinterface

// File: rtl/nv_nvdla_cdma_wt_wgs_splitter.sv
// Splits CDMA weight-group descriptors into MAX_BURST-aligned weight DMA reads.
// Optional perf counters are built when NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN is defined.
module nv_nvdla_cdma_wt_wgs_splitter #(
    parameter int MAX_BURST = 8,
    parameter int BURST_W   = 3
) (
    input  logic        clk,
    input  logic        reset_,
    nv_nvdla_cdma_wt_wgs_splitter_if.master bus,
    input  logic        layer_start,
    input  logic [31:0] reg2dp_weight_addr,
    output logic        busy,
    output logic        layer_done
`ifdef NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN
    ,
    output logic [31:0] perf_burst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t           state;
    logic [26:0]      addr_atom;
    logic [15:0]      remaining;
    logic             last_grp;

    logic [15:0]      fetch_cnt;
    logic             fetch_last;
    logic [BURST_W:0] fetch_n;
    logic [BURST_W:0] cur_n;
    logic [BURST_W:0] nx_n;
    logic [26:0]      addr_nx;
    logic [15:0]      rem_nx;
    logic             unused_bits;

    // Atoms left before the next MAX_BURST boundary, clipped to what the group still needs.
    function automatic logic [BURST_W:0] burst_atoms(input logic [15:0] rem,
                                                     input logic [26:0] atom);
        logic [BURST_W:0] room;
        room = (BURST_W+1)'(MAX_BURST) - {1'b0, atom[BURST_W-1:0]};
        if (rem < 16'(room))
            return rem[BURST_W:0];
        return room;
    endfunction

    assign fetch_cnt  = bus.wgs_rd_data[15:0];
    assign fetch_last = bus.wgs_rd_data[16];
    assign fetch_n    = burst_atoms(fetch_cnt, addr_atom);
    assign cur_n      = burst_atoms(remaining, addr_atom);
    assign addr_nx    = addr_atom + 27'(cur_n);
    assign rem_nx     = remaining - 16'(cur_n);
    // Precompute the follow-on burst so the next request appears the cycle after acceptance.
    assign nx_n       = burst_atoms(rem_nx, addr_nx);

    assign unused_bits = ^{reg2dp_weight_addr[4:0], bus.wgs_rd_data[31:17]};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state             <= IDLE;
            addr_atom         <= '0;
            remaining         <= '0;
            last_grp          <= 1'b0;
            bus.wgs_rd_ready  <= 1'b0;
            bus.dma_req_valid <= 1'b0;
            bus.dma_req_addr  <= '0;
            bus.dma_req_size  <= '0;
            busy              <= 1'b0;
            layer_done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (layer_start) begin
                        addr_atom        <= reg2dp_weight_addr[31:5];
                        state            <= FETCH;
                        bus.wgs_rd_ready <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.wgs_rd_req) begin
                        remaining <= fetch_cnt;
                        last_grp  <= fetch_last;
                        if (fetch_cnt != 16'd0) begin
                            state             <= ISSUE;
                            bus.wgs_rd_ready  <= 1'b0;
                            bus.dma_req_valid <= 1'b1;
                            bus.dma_req_addr  <= {addr_atom, 5'b0};
                            bus.dma_req_size  <= BURST_W'(fetch_n - 1'b1);
                        end else if (fetch_last) begin
                            state            <= DONE;
                            bus.wgs_rd_ready <= 1'b0;
                            layer_done       <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.dma_req_ready) begin
                        addr_atom <= addr_nx;
                        remaining <= rem_nx;
                        if (rem_nx == 16'd0) begin
                            bus.dma_req_valid <= 1'b0;
                            if (last_grp) begin
                                state      <= DONE;
                                layer_done <= 1'b1;
                            end else begin
                                state            <= FETCH;
                                bus.wgs_rd_ready <= 1'b1;
                            end
                        end else begin
                            bus.dma_req_addr <= {addr_nx, 5'b0};
                            bus.dma_req_size <= BURST_W'(nx_n - 1'b1);
                        end
                    end
                end
                DONE: begin
                    layer_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN
    logic perf_clr;
    assign perf_clr = (state == IDLE) && layer_start;

    // Saturating counters; cleared when a new layer is accepted.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            perf_burst_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (perf_clr) begin
            perf_burst_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (bus.dma_req_valid) begin
            if (bus.dma_req_ready && perf_burst_cnt != 32'hFFFF_FFFF)
                perf_burst_cnt <= perf_burst_cnt + 32'd1;
            if (!bus.dma_req_ready && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_wgs_splitter.sv
// Directed bench for the weight-group splitter: FIFO model, DMA acceptance log, per-scenario checks.
module tb_nv_nvdla_cdma_wt_wgs_splitter;
    localparam int MAX_BURST = 8;
    localparam int BURST_W   = 3;

    logic        clk = 1'b0;
    logic        reset_;
    logic        layer_start;
    logic [31:0] base;
    logic        busy;
    logic        layer_done;
`ifdef NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN
    logic [31:0] perf_burst_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    nv_nvdla_cdma_wt_wgs_splitter_if #(.BURST_W(BURST_W)) bus();

    nv_nvdla_cdma_wt_wgs_splitter #(.MAX_BURST(MAX_BURST), .BURST_W(BURST_W)) dut (
        .clk                (clk),
        .reset_             (reset_),
        .bus                (bus),
        .layer_start        (layer_start),
        .reg2dp_weight_addr (base),
        .busy               (busy),
        .layer_done         (layer_done)
`ifdef NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN
        ,
        .perf_burst_cnt     (perf_burst_cnt),
        .perf_stall_cnt     (perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [31:0]        fifo_q   [$];
    logic [31:0]        acc_addr [$];
    logic [BURST_W-1:0] acc_size [$];
    int                 acc_cyc  [$];

    // Observe handshakes on the pre-edge values.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_) begin
            if (bus.dma_req_valid && bus.dma_req_ready) begin
                acc_addr.push_back(bus.dma_req_addr);
                acc_size.push_back(bus.dma_req_size);
                acc_cyc.push_back(cyc);
            end
            if (bus.wgs_rd_req && bus.wgs_rd_ready) begin
                pops <= pops + 1;
                void'(fifo_q.pop_front());
            end
            if (layer_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    // FIFO output model.
    initial begin
        bus.wgs_rd_req  = 1'b0;
        bus.wgs_rd_data = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.wgs_rd_req  = (fifo_q.size() != 0);
            bus.wgs_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] desc(input logic last, input logic [15:0] cnt);
        return {15'h0, last, cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic [31:0] b);
        base        = b;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.dma_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        tick();
        total++; if (bus.dma_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.dma_req_valid); end
        total++; if (bus.dma_req_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.dma_req_addr); end
        total++; if (bus.dma_req_size !== 3'd0) begin bad++; $display("FAIL rst_size got=%0d want=0", bus.dma_req_size); end
        total++; if (bus.wgs_rd_ready !== 1'b0) begin bad++; $display("FAIL rst_rd_ready got=%b want=0", bus.wgs_rd_ready); end
        total++; if (busy !== 1'b0 || layer_done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b want=00", busy, layer_done); end
        reset_ = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || bus.wgs_rd_ready !== 1'b0) begin bad++; $display("FAIL idle_after_rst busy=%b rdy=%b want=0 0", busy, bus.wgs_rd_ready); end
    endtask

    task automatic test_aligned();
        logic [31:0]        ea [3] = '{32'h1000, 32'h1100, 32'h1200};
        logic [BURST_W-1:0] es [3] = '{3'd7, 3'd7, 3'd3};
        int a0, d0, p0;
        bit ok;
        a0 = acc_addr.size(); d0 = done_cnt; p0 = pops;
        bus.dma_req_ready = 1'b1;
        fifo_q.push_back(desc(1'b1, 16'd20));
        start_layer(32'h1000);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL aligned_timeout got=no_done want=done"); end
        total++; if (acc_addr.size() - a0 !== 3) begin bad++; $display("FAIL aligned_count got=%0d want=3", acc_addr.size() - a0); end
        for (int i = 0; i < 3; i++) begin
            if (a0 + i < acc_addr.size()) begin
                total++;
                if (acc_addr[a0+i] !== ea[i] || acc_size[a0+i] !== es[i]) begin
                    bad++; $display("FAIL aligned_burst%0d got=%h/%0d want=%h/%0d", i, acc_addr[a0+i], acc_size[a0+i], ea[i], es[i]);
                end
            end
        end
        if (acc_addr.size() >= a0 + 3) begin
            total++; if (acc_cyc[a0+2] - acc_cyc[a0] !== 2) begin bad++; $display("FAIL aligned_b2b got=%0d want=2", acc_cyc[a0+2] - acc_cyc[a0]); end
            total++; if (done_cyc !== acc_cyc[a0+2] + 1) begin bad++; $display("FAIL aligned_done_cyc got=%0d want=%0d", done_cyc, acc_cyc[a0+2] + 1); end
        end
        tick(); tick();
        total++; if (done_cnt - d0 !== 1 || busy !== 1'b0 || layer_done !== 1'b0) begin
            bad++; $display("FAIL aligned_single_done got=%0d busy=%b want=1 busy=0", done_cnt - d0, busy);
        end
        total++; if (pops - p0 !== 1) begin bad++; $display("FAIL aligned_pops got=%0d want=1", pops - p0); end
    endtask

    task automatic test_misaligned();
        logic [31:0]        ea [2] = '{32'h1060, 32'h1100};
        logic [BURST_W-1:0] es [2] = '{3'd4, 3'd4};
        int a0, d0;
        bit ok;
        a0 = acc_addr.size(); d0 = done_cnt;
        bus.dma_req_ready = 1'b1;
        fifo_q.push_back(desc(1'b1, 16'd10));
        start_layer(32'h1060);
        wait_done(d0, ok);
        total++; if (!ok || acc_addr.size() - a0 !== 2) begin bad++; $display("FAIL misaligned_count got=%0d want=2", acc_addr.size() - a0); end
        for (int i = 0; i < 2; i++) begin
            if (a0 + i < acc_addr.size()) begin
                total++;
                if (acc_addr[a0+i] !== ea[i] || acc_size[a0+i] !== es[i]) begin
                    bad++; $display("FAIL misaligned_burst%0d got=%h/%0d want=%h/%0d", i, acc_addr[a0+i], acc_size[a0+i], ea[i], es[i]);
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_carry();
        logic [31:0]        ea [2] = '{32'h0, 32'hA0};
        logic [BURST_W-1:0] es [2] = '{3'd4, 3'd2};
        int a0, d0, p0;
        bit ok;
        a0 = acc_addr.size(); d0 = done_cnt; p0 = pops;
        bus.dma_req_ready = 1'b1;
        // Reserved descriptor bits set to show they are ignored.
        fifo_q.push_back(desc(1'b0, 16'd5) | 32'hFFFE_0000);
        fifo_q.push_back(desc(1'b1, 16'd3));
        start_layer(32'h0);
        wait_done(d0, ok);
        total++; if (!ok || acc_addr.size() - a0 !== 2) begin bad++; $display("FAIL carry_count got=%0d want=2", acc_addr.size() - a0); end
        for (int i = 0; i < 2; i++) begin
            if (a0 + i < acc_addr.size()) begin
                total++;
                if (acc_addr[a0+i] !== ea[i] || acc_size[a0+i] !== es[i]) begin
                    bad++; $display("FAIL carry_burst%0d got=%h/%0d want=%h/%0d", i, acc_addr[a0+i], acc_size[a0+i], ea[i], es[i]);
                end
            end
        end
        if (acc_addr.size() >= a0 + 2) begin
            total++; if (acc_cyc[a0+1] - acc_cyc[a0] !== 2) begin bad++; $display("FAIL carry_turnaround got=%0d want=2", acc_cyc[a0+1] - acc_cyc[a0]); end
        end
        tick(); tick();
        total++; if (done_cnt - d0 !== 1 || pops - p0 !== 2) begin bad++; $display("FAIL carry_done_pops got=%0d/%0d want=1/2", done_cnt - d0, pops - p0); end
    endtask

    task automatic test_zero();
        int a0, d0, p0;
        bit ok;
        a0 = acc_addr.size(); d0 = done_cnt; p0 = pops;
        fifo_q.push_back(desc(1'b0, 16'd0));
        fifo_q.push_back(desc(1'b1, 16'd0));
        start_layer(32'h4000);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_done got=no_done want=done"); end
        tick(); tick();
        total++; if (acc_addr.size() - a0 !== 0) begin bad++; $display("FAIL zero_no_req got=%0d want=0", acc_addr.size() - a0); end
        total++; if (pops - p0 !== 2 || done_cnt - d0 !== 1) begin bad++; $display("FAIL zero_pops_done got=%0d/%0d want=2/1", pops - p0, done_cnt - d0); end
    endtask

    task automatic test_wrap();
        logic [31:0]        ea [2] = '{32'hFFFF_FFE0, 32'h0};
        logic [BURST_W-1:0] es [2] = '{3'd0, 3'd2};
        int a0, d0;
        bit ok;
        a0 = acc_addr.size(); d0 = done_cnt;
        bus.dma_req_ready = 1'b1;
        fifo_q.push_back(desc(1'b1, 16'd4));
        // Low five address bits must be dropped.
        start_layer(32'hFFFF_FFFF);
        wait_done(d0, ok);
        total++; if (!ok || acc_addr.size() - a0 !== 2) begin bad++; $display("FAIL wrap_count got=%0d want=2", acc_addr.size() - a0); end
        for (int i = 0; i < 2; i++) begin
            if (a0 + i < acc_addr.size()) begin
                total++;
                if (acc_addr[a0+i] !== ea[i] || acc_size[a0+i] !== es[i]) begin
                    bad++; $display("FAIL wrap_burst%0d got=%h/%0d want=%h/%0d", i, acc_addr[a0+i], acc_size[a0+i], ea[i], es[i]);
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int a0, d0, p0;
        bit ok;
        a0 = acc_addr.size(); d0 = done_cnt; p0 = pops;
        bus.dma_req_ready = 1'b0;
        fifo_q.push_back(desc(1'b1, 16'd16));
        start_layer(32'h100);
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_valid_timeout got=no_valid want=valid"); end
        bus.dma_req_ready = 1'b1;
        tick();
        bus.dma_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.dma_req_valid !== 1'b1 || bus.dma_req_addr !== 32'h200 || bus.dma_req_size !== 3'd7 || bus.wgs_rd_ready !== 1'b0) begin
                bad++; $display("FAIL bp_stable%0d got=v%b %h/%0d rdy=%b want=v1 00000200/7 rdy=0", i, bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, bus.wgs_rd_ready);
            end
            tick();
        end
        bus.dma_req_ready = 1'b1;
        wait_done(d0, ok);
        total++; if (!ok || acc_addr.size() - a0 !== 2) begin bad++; $display("FAIL bp_count got=%0d want=2", acc_addr.size() - a0); end
        if (acc_addr.size() >= a0 + 2) begin
            total++; if (acc_addr[a0+1] !== 32'h200) begin bad++; $display("FAIL bp_second got=%h want=00000200", acc_addr[a0+1]); end
        end
        total++; if (pops - p0 !== 1) begin bad++; $display("FAIL bp_pops got=%0d want=1", pops - p0); end
`ifdef NV_NVDLA_CDMA_WT_WGS_SPLIT_PERF_EN
        total++; if (perf_stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d want=5", perf_stall_cnt); end
        total++; if (perf_burst_cnt !== 32'd2) begin bad++; $display("FAIL perf_burst got=%0d want=2", perf_burst_cnt); end
`endif
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int a0, d0;
        bit ok;
        bus.dma_req_ready = 1'b0;
        fifo_q.push_back(desc(1'b1, 16'd64));
        start_layer(32'h2000);
        wait_valid(ok);
        total++; if (!ok || bus.dma_req_addr !== 32'h2000) begin bad++; $display("FAIL rm_issue got=%h want=00002000", bus.dma_req_addr); end
        reset_ = 1'b0;
        #1;
        total++; if (bus.dma_req_valid !== 1'b0 || bus.dma_req_addr !== 32'h0 || bus.dma_req_size !== 3'd0 || busy !== 1'b0 || bus.wgs_rd_ready !== 1'b0 || layer_done !== 1'b0) begin
            bad++; $display("FAIL rm_async got=v%b %h/%0d busy=%b want=all0", bus.dma_req_valid, bus.dma_req_addr, bus.dma_req_size, busy);
        end
        tick();
        reset_ = 1'b1;
        bus.dma_req_ready = 1'b1;
        a0 = acc_addr.size();
        repeat (5) tick();
        total++; if (acc_addr.size() - a0 !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rm_no_reissue got=%0d busy=%b want=0 busy=0", acc_addr.size() - a0, busy); end
        d0 = done_cnt;
        start_layer(32'h3000);
        tick();
        start_layer(32'h5000);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b want=1", busy); end
        fifo_q.push_back(desc(1'b1, 16'd3));
        wait_done(d0, ok);
        total++; if (!ok || acc_addr.size() - a0 !== 1) begin bad++; $display("FAIL rm_count got=%0d want=1", acc_addr.size() - a0); end
        if (acc_addr.size() > a0) begin
            total++; if (acc_addr[a0] !== 32'h3000 || acc_size[a0] !== 3'd2) begin bad++; $display("FAIL rm_ignored_start got=%h/%0d want=00003000/2", acc_addr[a0], acc_size[a0]); end
        end
        tick(); tick();
    endtask

    initial begin
        reset_            = 1'b0;
        layer_start       = 1'b0;
        base              = 32'h0;
        bus.dma_req_ready = 1'b0;
        test_reset();
        test_aligned();
        test_misaligned();
        test_carry();
        test_zero();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
